// File: rtl/twiddle_seed_exp_if.sv
// Start/operand/result bundle between the FFT group sequencer and the seed
// twiddle exponentiation engine.
interface twiddle_seed_exp_if #(
   parameter int P_WIDTH = 64,
   parameter int E_WIDTH = 14
);
   logic               start;
   logic [P_WIDTH-1:0] base_in;
   logic [E_WIDTH-1:0] exp_in;
   logic [P_WIDTH-1:0] N_in;
   logic [P_WIDTH-1:0] seed_out;
   logic [P_WIDTH-1:0] step_out;
   logic               busy;
   logic               done;

   modport master (
      output start, base_in, exp_in, N_in,
      input  seed_out, step_out, busy, done
   );

   modport slave (
      input  start, base_in, exp_in, N_in,
      output seed_out, step_out, busy, done
   );
endinterface

// File: rtl/twiddle_seed_exp.sv
// Seed twiddle generator: W^E mod N by MSB-first square-and-multiply built on a
// bit-serial interleaved modular multiplier (one multiplier bit per cycle).
module twiddle_seed_exp #(
   parameter int P_WIDTH = 64,
   parameter int E_WIDTH = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   twiddle_seed_exp_if.slave bus
);

   localparam int JW = (P_WIDTH > 1) ? $clog2(P_WIDTH) : 1;
   localparam int KW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
   localparam int TW = P_WIDTH + 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SQR  = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state_q, state_d;

   logic [P_WIDTH-1:0] a_q;
   logic [P_WIDTH-1:0] n_q;
   logic [P_WIDTH-1:0] r_q;
   logic [P_WIDTH-1:0] t_q;
   logic [E_WIDTH-1:0] e_q;
   logic [KW-1:0]      k_q;
   logic [JW-1:0]      j_q;

   logic               start_acc;
   logic               mult_active;
   logic               mult_last;
   logic               e_bit;
   logic               advance;
   logic               to_done;
   logic [P_WIDTH-1:0] x_op;
   logic [TW-1:0]      t_acc;
   logic [P_WIDTH-1:0] t_next;

   // One conditional subtraction of the modulus; applied twice per step since
   // 2T + X < 3N whenever T, X < N.
   function automatic logic [TW-1:0] cond_sub(input logic [TW-1:0] v,
                                              input logic [TW-1:0] m);
      return (v >= m) ? (v - m) : v;
   endfunction

   always_comb begin
      start_acc   = (state_q == S_IDLE) && bus.start;
      mult_active = (state_q == S_SQR) || (state_q == S_MUL);
      mult_last   = mult_active && (j_q == '0);
      e_bit       = e_q[k_q];
      advance     = mult_last && ((state_q == S_MUL) || !e_bit);
      to_done     = advance && (k_q == '0);
      // The multiplier operand Y is always R; only X differs between SQR and MUL.
      x_op        = (state_q == S_MUL) ? a_q : r_q;
      t_acc       = {1'b0, t_q, 1'b0} + (r_q[j_q] ? {2'b00, x_op} : {TW{1'b0}});
      t_next      = P_WIDTH'(cond_sub(cond_sub(t_acc, {2'b00, n_q}), {2'b00, n_q}));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_SQR;
            end
         end
         S_SQR: begin
            if (mult_last && e_bit) begin
               state_d = S_MUL;
            end else if (advance) begin
               state_d = to_done ? S_DONE : S_SQR;
            end
         end
         S_MUL: begin
            if (advance) begin
               state_d = to_done ? S_DONE : S_SQR;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      bus.busy = (state_q != S_IDLE);
      bus.done = (state_q == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q          <= '0;
         n_q          <= '0;
         r_q          <= '0;
         t_q          <= '0;
         e_q          <= '0;
         k_q          <= '0;
         j_q          <= '0;
         bus.seed_out <= '0;
         bus.step_out <= '0;
      end else if (start_acc) begin
         a_q          <= bus.base_in;
         e_q          <= bus.exp_in;
         n_q          <= bus.N_in;
         r_q          <= P_WIDTH'(1);
         t_q          <= '0;
         j_q          <= JW'(P_WIDTH - 1);
         k_q          <= KW'(E_WIDTH - 1);
         bus.step_out <= bus.base_in;
      end else if (mult_active) begin
         if (mult_last) begin
            // Multiply complete: commit to R and rearm the bit counter.
            r_q <= t_next;
            t_q <= '0;
            j_q <= JW'(P_WIDTH - 1);
            if (advance && !to_done) begin
               k_q <= k_q - KW'(1);
            end
            if (to_done) begin
               bus.seed_out <= t_next;
            end
         end else begin
            t_q <= t_next;
            j_q <= j_q - JW'(1);
         end
      end
   end

endmodule

// File: tb/tb_twiddle_seed_exp.sv
// Scoreboard bench for twiddle_seed_exp: stimulus pushes expected results,
// a negedge monitor pops and checks value, step, done cycle and busy length.
module tb_twiddle_seed_exp;

   localparam int          PW = 64;
   localparam int          EW = 14;
   localparam logic [63:0] NQ = 64'hFFFFFFFF00000001;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   twiddle_seed_exp_if #(.P_WIDTH(PW), .E_WIDTH(EW)) bus ();

   twiddle_seed_exp #(.P_WIDTH(PW), .E_WIDTH(EW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [63:0] seed;
      logic [63:0] step;
      int          done_cyc;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   last_c = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int lat_of(input logic [EW-1:0] e);
      int pop = 0;
      for (int i = 0; i < EW; i++) pop += int'(e[i]);
      return (EW + pop) * PW + 1;
   endfunction

   function automatic logic [63:0] powmod(input logic [63:0] b, input logic [EW-1:0] e,
                                          input logic [63:0] n);
      logic [127:0] r;
      r = 128'd1;
      for (int i = EW - 1; i >= 0; i--) begin
         r = (r * r) % {64'd0, n};
         if (e[i]) r = (r * {64'd0, b}) % {64'd0, n};
      end
      return r[63:0];
   endfunction

   task automatic finish_up();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask

   // Drive one start in the current cycle; the posedge ending it samples start.
   task automatic issue(input logic [63:0] b, input logic [EW-1:0] e, input logic [63:0] n,
                        input logic [63:0] seed, input bit push, input bit hold);
      exp_t t;
      @(posedge clk); #1;
      bus.start   = 1'b1;
      bus.base_in = b;
      bus.exp_in  = e;
      bus.N_in    = n;
      last_c      = cyc;
      if (push) begin
         t.seed     = seed;
         t.step     = b;
         t.lat      = lat_of(e);
         t.done_cyc = cyc + t.lat;
         exp_q.push_back(t);
      end
      if (!hold) begin
         @(posedge clk); #1;
         bus.start   = 1'b0;
         bus.base_in = {$urandom(), $urandom()};
         bus.exp_in  = EW'($urandom());
         bus.N_in    = {$urandom(), $urandom()};
      end
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL timeout actual=pending(%0d) required=0 (cycle %0d)", exp_q.size(), cyc);
         finish_up();
      end
   endtask

   // Monitor
   initial begin
      int   run;
      bit   chk_idle;
      exp_t t;
      run = 0;
      chk_idle = 1'b0;
      forever begin
         @(negedge clk);
         if (chk_idle) begin
            chk("post_done_busy", 64'(bus.busy), 64'd0);
            chk("post_done_done", 64'(bus.done), 64'd0);
            chk_idle = 1'b0;
         end
         if (bus.busy) run++;
         else run = 0;
         if (bus.done) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
               t = exp_q.pop_front();
               chk("seed", bus.seed_out, t.seed);
               chk("step", bus.step_out, t.step);
               chk("done_cycle", 64'(cyc), 64'(t.done_cyc));
               chk("busy_cycles", 64'(run), 64'(t.lat));
               chk_idle = 1'b1;
            end
         end
      end
   end

   // Stimulus
   initial begin
      exp_t        t;
      logic [63:0] n, b;
      logic [EW-1:0] e;
      bus.start   = 1'b0;
      bus.base_in = '0;
      bus.exp_in  = '0;
      bus.N_in    = '0;
      rst_n       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_seed", bus.seed_out, 64'd0);
      chk("rst_step", bus.step_out, 64'd0);
      rst_n = 1'b1;

      issue(64'd7, 14'd0, NQ, 64'd1, 1'b1, 1'b0);             drain(1000);
      issue(64'd7, 14'd1, NQ, 64'd7, 1'b1, 1'b0);             drain(1100);
      issue(64'd2, 14'd64, NQ, 64'h00000000FFFFFFFF, 1'b1, 1'b0); drain(1100);
      issue(NQ - 64'd1, 14'd3, NQ, NQ - 64'd1, 1'b1, 1'b0);   drain(1200);
      issue(64'd0, 14'd5, NQ, 64'd0, 1'b1, 1'b0);             drain(1200);
      issue(64'd0, 14'd0, NQ, 64'd1, 1'b1, 1'b0);             drain(1000);
      issue(64'd2, 14'd10, 64'd13, 64'd10, 1'b1, 1'b0);       drain(1200);

      // Maximum exponent with a second start pulse at C+100 that must be ignored.
      issue(64'd3, 14'h3FFF, NQ, powmod(64'd3, 14'h3FFF, NQ), 1'b1, 1'b0);
      repeat (99) @(posedge clk);
      #1;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      drain(2000);
      repeat (3) @(negedge clk);
      chk("repulse_idle_busy", 64'(bus.busy), 64'd0);

      // start held high: back-to-back runs, the second accepted right after DONE.
      issue(64'd7, 14'd1, NQ, 64'd7, 1'b1, 1'b1);
      t.seed     = 64'd7;
      t.step     = 64'd7;
      t.lat      = 961;
      t.done_cyc = last_c + 961 + 1 + 961;
      exp_q.push_back(t);
      repeat (2 * 961 + 1) @(posedge clk);
      #1;
      bus.start = 1'b0;
      drain(100);

      // Reset mid-operation: no done for the aborted run, outputs cleared at once.
      issue(64'd9, 14'h2345, NQ, 64'd0, 1'b0, 1'b0);
      repeat (499) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_done", 64'(bus.done), 64'd0);
      chk("abort_seed", bus.seed_out, 64'd0);
      chk("abort_step", bus.step_out, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      issue(64'd5, 14'd2, NQ, 64'd25, 1'b1, 1'b0);            drain(1100);

      for (int i = 0; i < 20; i++) begin
         n = {$urandom(), $urandom()} | 64'd1;
         if (n < 64'd3) n = 64'd3;
         b = {$urandom(), $urandom()} % n;
         e = EW'($urandom());
         issue(b, e, n, powmod(b, e, n), 1'b1, 1'b0);
         drain(2000);
      end

      repeat (3) @(negedge clk);
      finish_up();
   end

endmodule
